serdes_tx_scheduler: RTL and testbench
======================================

# serdes_tx_scheduler

Symbol-level transmit scheduler in front of the 8b/10b serializer. Runs link bring-up: a comma training sequence after enable. Then arbitrates round-robin between NUM_REQ byte-stream requesters, granting bounded bursts, and fills every unused symbol slot with an idle comma. Drives one byte plus K-flag per i_Clk cycle into the encoder input.

## Interface
- DATA_WIDTH, 8: symbol byte width; only 8 is supported.
- NUM_REQ, 2: number of requesters, 2..8.
- TRAIN_LEN, 16: number of K28.5 symbols in training, ≥1.
- MAX_BURST, 4: maximum data beats per grant, ≥1.

Ports:
- i_Clk  in  1  symbol clock; all logic on posedge. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous active-high reset.
- i_En  in  1  link enable.
- i_Req_Valid  in  NUM_REQ  per-requester byte valid.
- i_Req_Data  in  NUM_REQ*DATA_WIDTH  requester r occupies bits [r*8 +: 8].
- i_Req_Last  in  NUM_REQ  final byte of the requester's message.
- o_Req_Ready  out  NUM_REQ  combinational accept, one-hot or zero.
- o_Sym_Data  out  8  symbol byte to encoder.
- o_Sym_K  out  1  1 = control symbol.
- o_Sym_Valid  out  1  symbol slot active.
- o_Link_Up  out  1  training complete.
- o_State  out  3  current FSM state encoding, for debug.

## Operation
- States: OFF, TRAIN, IDLE, SOF, BURST, EOF. SOF and EOF exist only with the macro defined (see Configuration).
- OFF
  - Outputs: o_Sym_Valid=0, o_Link_Up=0.
  - i_En=1 → TRAIN.
- TRAIN
  - Emits 0xBC with K=1 each cycle.
  - After exactly TRAIN_LEN symbols → IDLE.
  - i_En=0 → OFF immediately.
- IDLE
  - Emits 0xBC with K=1 each cycle; o_Link_Up=1.
  - If any i_Req_Valid is set, grant the first valid requester searching upward from (last_grant+1) mod NUM_REQ. The pointer resets to NUM_REQ-1, so requester 0 wins first.
  - On grant → BURST (or SOF). The current cycle still emits idle.
  - i_En=0 → OFF, with priority over a grant.
- BURST
  - o_Req_Ready[grant]=1; all other ready bits are 0.
  - An accepted beat (valid&&ready) emits the data byte with K=0.
  - Exit to IDLE (or EOF) after an accepted beat with i_Req_Last=1, or when the beat count reaches MAX_BURST.
  - If the granted valid is low, that cycle emits idle 0xBC/K=1, accepts nothing, and exits the burst.
  - Simultaneous last and MAX_BURST: exit once.
- i_En dropping during BURST/SOF/EOF is honoured only when the burst ends, then → OFF.
- The round-robin pointer updates to grant on entry to BURST.
- The beat counter is ceil(log2(MAX_BURST+1)) bits and clears on burst entry.
- The training counter is ceil(log2(TRAIN_LEN+1)) bits and never wraps; it saturates at TRAIN_LEN.

## Timing
- Reset values:
  - o_Sym_Data=0x00, o_Sym_K=0, o_Sym_Valid=0, o_Link_Up=0, o_Req_Ready=0, o_State=OFF.
  - Round-robin pointer NUM_REQ-1; counters 0.
- All o_Sym_* outputs are registered. A symbol decided in cycle n appears after posedge n+1, giving 1-cycle latency from accept to o_Sym_Data.
- o_Req_Ready is decoded combinationally from the registered state and grant. It never depends on i_Req_Valid, so there is no combinational loop.
- i_En rising at edge n: TRAIN at n+1. The first training symbol is visible after n+2; o_Link_Up rises with the first idle symbol.
- Reset mid-burst: o_Req_Ready=0 from the same edge. The partial message is abandoned and the requester must retransmit.
- Back-to-back grants always have at least one IDLE cycle (or EOF+idle) between bursts.

## Configuration
- SERDES_TX_SOF_EOF_EN
  - Defined: IDLE grant → SOF, which emits K27.7 (0xFB, K=1) for one cycle and then → BURST. Burst exit → EOF, which emits K29.7 (0xFD, K=1) for one cycle and then → IDLE.
  - Not defined: SOF/EOF states and encodings are absent, and bursts are unframed.

## Structure
- Package serdes_pkg holds:
  - the state enum tx_sched_state_t;
  - the constants K28_5=8'hBC, K27_7=8'hFB, K29_7=8'hFD;
  - the symbol struct {logic [7:0] data; logic k;}.
- Sub-module rr_arbiter (parameter NUM_REQ): inputs request vector and pointer; outputs one-hot grant, grant index, and any_req.

## Test plan
- Reset, i_En=1, TRAIN_LEN=16 → exactly 16 × (0xBC, K=1) symbols, then o_Link_Up=1 and continuous idles.
- Req0 sends 0x11,0x22,0x33 with last on 0x33 → 0x11,0x22,0x33 appear with K=0 at consecutive cycles, 1 cycle after each accept; then idle.
- Both requesters valid continuously, MAX_BURST=4 → grants alternate 0,1,0. Each burst is exactly 4 bytes with ≥1 idle between bursts.
- Req1 drops valid after 2 of 4 beats → 2 bytes, then 0xBC/K=1, then IDLE. The next grant goes to req0.
- i_rst asserted mid-burst → outputs return to reset values next edge. Link retrains only after i_En is seen in OFF.
- With SERDES_TX_SOF_EOF_EN: a single-byte message 0xA5 → 0xFB(K), 0xA5, 0xFD(K), 0xBC(K).

Source files
------------

// File: rtl/serdes_tx_scheduler_pkg.sv
// Shared types and K-code constants for the serdes transmit scheduler.
// SOF/EOF framing states exist only when SERDES_TX_SOF_EOF_EN is defined.
package serdes_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;

`ifdef SERDES_TX_SOF_EOF_EN
    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StTrain = 3'd1,
        StIdle  = 3'd2,
        StSof   = 3'd3,
        StBurst = 3'd4,
        StEof   = 3'd5
    } tx_sched_state_t;
`else
    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StTrain = 3'd1,
        StIdle  = 3'd2,
        StBurst = 3'd4
    } tx_sched_state_t;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       k;
    } sym_t;

endpackage

// File: rtl/serdes_tx_scheduler_if.sv
// Requester handshake and encoder symbol bus of the transmit scheduler.
// master = requesters/encoder side, slave = scheduler.
interface serdes_tx_scheduler_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            i_Req_Valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data;
    logic [NUM_REQ-1:0]            i_Req_Last;
    logic [NUM_REQ-1:0]            o_Req_Ready;
    logic [DATA_WIDTH-1:0]         o_Sym_Data;
    logic                          o_Sym_K;
    logic                          o_Sym_Valid;

    modport master (
        output i_Req_Valid, i_Req_Data, i_Req_Last,
        input  o_Req_Ready, o_Sym_Data, o_Sym_K, o_Sym_Valid
    );

    modport slave (
        input  i_Req_Valid, i_Req_Data, i_Req_Last,
        output o_Req_Ready, o_Sym_Data, o_Sym_K, o_Sym_Valid
    );
endinterface

// File: rtl/serdes_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request searching upward from ptr+1 (mod NUM_REQ).
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IdxW-1:0]    grant_idx,
    output logic               any_req
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    logic            found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(ptr) + i) % NUM_REQ;
            cand_idx = IdxW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Symbol scheduler ahead of the 8b/10b encoder: comma training, round-robin bursts, idle fill.
// Optional SOF/EOF framing (K27.7 / K29.7) enabled by defining SERDES_TX_SOF_EOF_EN.
module serdes_tx_scheduler
    import serdes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TRAIN_LEN  = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_rst,
    input  logic                  i_En,
    serdes_tx_scheduler_if.slave  bus,
    output logic                  o_Link_Up,
    output logic [2:0]            o_State
);

    localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TrainW = $clog2(TRAIN_LEN + 1);
    localparam int unsigned BeatW  = $clog2(MAX_BURST + 1);
    localparam sym_t        SymIdle = '{data: K28_5, k: 1'b1};

    tx_sched_state_t state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic [TrainW-1:0] train_q, train_d;
    sym_t              sym_q, sym_d;
    logic              sym_valid_q, sym_valid_d;
    logic              link_up_q, link_up_d;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IdxW-1:0]       arb_idx;
    logic                  arb_any;
    logic                  beat_valid;
    logic                  beat_last;
    logic                  beat_done;
    logic [DATA_WIDTH-1:0] beat_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (bus.i_Req_Valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    assign beat_valid = bus.i_Req_Valid[grant_q];
    assign beat_last  = bus.i_Req_Last[grant_q];
    assign beat_data  = bus.i_Req_Data[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
    assign beat_done  = (beat_q + BeatW'(1)) == BeatW'(MAX_BURST);

    always_ff @(posedge i_Clk) begin
        if (i_rst) begin
            state_q     <= StOff;
            grant_q     <= '0;
            ptr_q       <= IdxW'(NUM_REQ - 1);
            beat_q      <= '0;
            train_q     <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            train_q     <= train_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            link_up_q   <= link_up_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        train_d = train_q;
        case (state_q)
            StOff: begin
                train_d = '0;
                beat_d  = '0;
                if (i_En) state_d = StTrain;
            end
            StTrain: begin
                if (!i_En) begin
                    state_d = StOff;
                end else begin
                    if (train_q != TrainW'(TRAIN_LEN)) train_d = train_q + TrainW'(1);
                    if (train_q == TrainW'(TRAIN_LEN - 1)) state_d = StIdle;
                end
            end
            StIdle: begin
                if (!i_En) begin
                    state_d = StOff;
                end else if (arb_any) begin
                    grant_d = arb_idx;
                    ptr_d   = arb_idx;
                    beat_d  = '0;
`ifdef SERDES_TX_SOF_EOF_EN
                    state_d = StSof;
`else
                    state_d = StBurst;
`endif
                end
            end
`ifdef SERDES_TX_SOF_EOF_EN
            StSof: state_d = StBurst;
            StEof: state_d = i_En ? StIdle : StOff;
`endif
            StBurst: begin
                if (beat_valid) beat_d = beat_q + BeatW'(1);
                // Last beat, full burst and a stalled requester all end the grant.
                if (!beat_valid || beat_last || beat_done) begin
`ifdef SERDES_TX_SOF_EOF_EN
                    state_d = StEof;
`else
                    state_d = i_En ? StIdle : StOff;
`endif
                end
            end
            default: state_d = StOff;
        endcase
    end

    always_comb begin
        sym_d       = '0;
        sym_valid_d = 1'b1;
        link_up_d   = 1'b1;
        case (state_q)
            StOff: begin
                sym_valid_d = 1'b0;
                link_up_d   = 1'b0;
            end
            StTrain: begin
                sym_d     = SymIdle;
                link_up_d = 1'b0;
            end
            StIdle: sym_d = SymIdle;
`ifdef SERDES_TX_SOF_EOF_EN
            StSof: sym_d = '{data: K27_7, k: 1'b1};
            StEof: sym_d = '{data: K29_7, k: 1'b1};
`endif
            StBurst: begin
                if (beat_valid) sym_d = '{data: beat_data, k: 1'b0};
                else            sym_d = SymIdle;
            end
            default: begin
                sym_valid_d = 1'b0;
                link_up_d   = 1'b0;
            end
        endcase
    end

    // Ready comes from registered state only, so it never loops back through valid.
    assign bus.o_Req_Ready = (state_q == StBurst) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.o_Sym_Data  = sym_q.data;
    assign bus.o_Sym_K     = sym_q.k;
    assign bus.o_Sym_Valid = sym_valid_q;
    assign o_Link_Up       = link_up_q;
    assign o_State         = state_q;

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Bench for serdes_tx_scheduler: training vector table, then scoreboarded burst scenarios.
module tb_serdes_tx_scheduler;
    import serdes_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned TL = 16;
    localparam int unsigned MB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       link_up;
    logic [2:0] state;

    serdes_tx_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(8)) bus ();

    serdes_tx_scheduler #(
        .DATA_WIDTH (8),
        .NUM_REQ    (NR),
        .TRAIN_LEN  (TL),
        .MAX_BURST  (MB)
    ) dut (
        .i_Clk     (clk),
        .i_rst     (rst),
        .i_En      (en),
        .bus       (bus),
        .o_Link_Up (link_up),
        .o_State   (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          en;
        logic          exp_valid;
        logic          exp_k;
        logic [7:0]    exp_data;
        logic          exp_link;
        logic [2:0]    exp_state;
        logic [NR-1:0] exp_ready;
    } vec_t;

    vec_t vecs[22];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [8:0] exp_q[$];

    logic [7:0] src_data[NR][16];
    logic       src_last[NR][16];
    int         src_len[NR];
    int         src_idx[NR];
    logic [NR-1:0] acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [7:0] d,
                                input logic k, input logic l, input logic [2:0] s);
        vec_t t;
        t.rst = r; t.en = e; t.exp_valid = v; t.exp_data = d; t.exp_k = k;
        t.exp_link = l; t.exp_state = s; t.exp_ready = '0;
        return t;
    endfunction

    task automatic push(input logic k, input logic [7:0] d);
        exp_q.push_back({k, d});
    endtask

    task automatic push_idle();
        push(1'b1, K28_5);
    endtask

    task automatic push_sof();
`ifdef SERDES_TX_SOF_EOF_EN
        push(1'b1, K27_7);
`endif
    endtask

    task automatic push_eof();
`ifdef SERDES_TX_SOF_EOF_EN
        push(1'b1, K29_7);
`endif
    endtask

    task automatic push_burst(input logic [7:0] first, input int n);
        push_sof();
        for (int i = 0; i < n; i++) push(1'b0, first + 8'(i));
        push_eof();
    endtask

    task automatic load(input int r, input logic [7:0] first, input logic [7:0] step,
                        input int n, input bit last_end);
        src_len[r] = n;
        src_idx[r] = 0;
        for (int i = 0; i < n; i++) begin
            src_data[r][i] = first + 8'(i) * step;
            src_last[r][i] = last_end && (i == n - 1);
        end
    endtask

    task automatic drive();
        logic [NR-1:0]   v;
        logic [NR*8-1:0] d;
        logic [NR-1:0]   l;
        v = '0; d = '0; l = '0;
        for (int r = 0; r < NR; r++) begin
            if (src_idx[r] < src_len[r]) begin
                v[r]       = 1'b1;
                d[r*8 +: 8] = src_data[r][src_idx[r]];
                l[r]       = src_last[r][src_idx[r]];
            end
        end
        bus.i_Req_Valid = v;
        bus.i_Req_Data  = d;
        bus.i_Req_Last  = l;
    endtask

    // One clock: note handshakes for the coming edge, sample after it, advance sources.
    task automatic cycle(input bit use_sb);
        logic [8:0] e;
        acc = bus.i_Req_Valid & bus.o_Req_Ready;
        @(posedge clk);
        #1;
        if (use_sb) begin
            check("ready_onehot", 32'($countones(bus.o_Req_Ready) <= 1), 32'd1);
            e = exp_q.pop_front();
            check("sym", {bus.o_Sym_Valid, bus.o_Sym_K, bus.o_Sym_Data}, {1'b1, e});
        end
        for (int r = 0; r < NR; r++) if (acc[r]) src_idx[r]++;
        drive();
    endtask

    task automatic run_sb(input string tag);
        while (exp_q.size() > 0) cycle(1'b1);
        for (int r = 0; r < NR; r++)
            check($sformatf("%s_consumed%0d", tag, r), src_idx[r], src_len[r]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(1, 0, 0, 8'h00, 0, 0, StOff);
        vecs[1] = mk(1, 1, 0, 8'h00, 0, 0, StOff);
        vecs[2] = mk(0, 0, 0, 8'h00, 0, 0, StOff);
        vecs[3] = mk(0, 1, 0, 8'h00, 0, 0, StTrain);
        for (int i = 4; i < 20; i++)
            vecs[i] = mk(0, 1, 1, K28_5, 1, 0, (i == 19) ? StIdle : StTrain);
        vecs[20] = mk(0, 1, 1, K28_5, 1, 1, StIdle);
        vecs[21] = mk(0, 1, 1, K28_5, 1, 1, StIdle);

        for (int r = 0; r < NR; r++) begin
            src_len[r] = 0;
            src_idx[r] = 0;
        end
        drive();

        // Reset values and training length
        for (int i = 0; i < 22; i++) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {bus.o_Sym_Valid, bus.o_Sym_K, bus.o_Sym_Data, link_up, state, bus.o_Req_Ready},
                  {vecs[i].exp_valid, vecs[i].exp_k, vecs[i].exp_data, vecs[i].exp_link,
                   vecs[i].exp_state, vecs[i].exp_ready});
        end

        // Both requesters continuously valid: grants 0,1,0,1 of MAX_BURST beats
        load(0, 8'hA0, 8'h01, 8, 1'b1);
        load(1, 8'hB0, 8'h01, 8, 1'b1);
        drive();
        push_idle(); push_burst(8'hA0, 4);
        push_idle(); push_burst(8'hB0, 4);
        push_idle(); push_burst(8'hA4, 4);
        push_idle(); push_burst(8'hB4, 4);
        push_idle(); push_idle();
        run_sb("rr");

        // Three-byte message from req0
        load(0, 8'h11, 8'h11, 3, 1'b1);
        drive();
        push_idle(); push_sof();
        push(1'b0, 8'h11); push(1'b0, 8'h22); push(1'b0, 8'h33);
        push_eof(); push_idle(); push_idle();
        run_sb("msg");

        // Req1 stalls after two beats without last
        load(1, 8'hC1, 8'h01, 2, 1'b0);
        drive();
        push_idle(); push_sof();
        push(1'b0, 8'hC1); push(1'b0, 8'hC2);
        push_idle(); push_eof(); push_idle();
        run_sb("drop");
        check("drop_state", state, StIdle);

        // After req1's grant, req0 must win the next one
        load(0, 8'hD0, 8'h01, 1, 1'b1);
        load(1, 8'hC3, 8'h01, 1, 1'b1);
        drive();
        push_idle(); push_burst(8'hD0, 1);
        push_idle(); push_burst(8'hC3, 1);
        push_idle(); push_idle();
        run_sb("after_drop");

        // Reset in the middle of a burst
        load(0, 8'hE0, 8'h01, 8, 1'b1);
        drive();
        repeat (3) cycle(1'b0);
        check("pre_rst_state", state, StBurst);
        check("pre_rst_ready", bus.o_Req_Ready, 32'h1);
        rst = 1'b1;
        cycle(1'b0);
        check("rst_ready", bus.o_Req_Ready, 32'h0);
        check("rst_outs", {bus.o_Sym_Valid, bus.o_Sym_K, bus.o_Sym_Data, link_up, state},
              {1'b0, 1'b0, 8'h00, 1'b0, StOff});
        src_len[0] = 0;
        drive();
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) cycle(1'b0);
        check("off_hold", {bus.o_Sym_Valid, state}, {1'b0, StOff});
        en = 1'b1;
        cycle(1'b0);
        check("retrain", state, StTrain);
        for (int i = 0; i < 40 && !link_up; i++) cycle(1'b0);
        check("relink", link_up, 32'h1);

        // Pointer was reset: req0 wins first; single-byte messages
        load(0, 8'hA5, 8'h01, 1, 1'b1);
        load(1, 8'h5A, 8'h01, 1, 1'b1);
        drive();
        push_idle(); push_burst(8'hA5, 1);
        push_idle(); push_burst(8'h5A, 1);
        push_idle();
        run_sb("single");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
